// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshakes on both sides.
// Sits between the register-file read stage and writeback.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   request handshake; select/A/B are captured on accept
//   select                opcode (AND XOR ADD OR LSL LSR SUB ASR MUL PASSB)
//   A, B                  operands; low SHAMT_WIDTH bits of B are the shift amount
//   out_valid / out_ready result handshake; F and flags are held until accepted
//   F                     result
//   zero/negative/carry/overflow  NZCV flags computed on F
//   illegal               opcode was unassigned (F and flags forced to 0)
//
// Single-cycle ops register their result on the accept edge. MUL runs an
// iterative shift-add over DATA_WIDTH cycles before the result is registered.
module alu_seq #(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned SEL_WIDTH   = 4,
  parameter int unsigned SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_WIDTH-1:0]  select,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] F,
  output logic                  zero,
  output logic                  negative,
  output logic                  carry,
  output logic                  overflow,
  output logic                  illegal
);

  localparam int unsigned CNT_WIDTH = $clog2(DATA_WIDTH);

  localparam logic [SEL_WIDTH-1:0] OP_AND   = SEL_WIDTH'(0);
  localparam logic [SEL_WIDTH-1:0] OP_XOR   = SEL_WIDTH'(1);
  localparam logic [SEL_WIDTH-1:0] OP_ADD   = SEL_WIDTH'(2);
  localparam logic [SEL_WIDTH-1:0] OP_OR    = SEL_WIDTH'(3);
  localparam logic [SEL_WIDTH-1:0] OP_LSL   = SEL_WIDTH'(4);
  localparam logic [SEL_WIDTH-1:0] OP_LSR   = SEL_WIDTH'(5);
  localparam logic [SEL_WIDTH-1:0] OP_SUB   = SEL_WIDTH'(6);
  localparam logic [SEL_WIDTH-1:0] OP_ASR   = SEL_WIDTH'(7);
  localparam logic [SEL_WIDTH-1:0] OP_MUL   = SEL_WIDTH'(8);
  localparam logic [SEL_WIDTH-1:0] OP_PASSB = SEL_WIDTH'(9);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   f_q, f_d;
  logic                    zero_q, zero_d;
  logic                    neg_q, neg_d;
  logic                    carry_q, carry_d;
  logic                    ovf_q, ovf_d;
  logic                    ill_q, ill_d;
  logic [DATA_WIDTH-1:0]   mcand_q, mcand_d;
  logic [DATA_WIDTH-1:0]   mplier_q, mplier_d;
  logic [DATA_WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;

  logic                    accept;
  logic [SHAMT_WIDTH-1:0]  shamt;
  logic [DATA_WIDTH:0]     add_ext;
  logic [DATA_WIDTH:0]     sub_ext;
  logic [DATA_WIDTH:0]     lsl_ext;
  logic [DATA_WIDTH:0]     lsr_ext;
  logic [DATA_WIDTH:0]     asr_ext;
  logic [DATA_WIDTH-1:0]   mul_acc_next;

  logic [DATA_WIDTH-1:0]   alu_f;
  logic                    alu_c;
  logic                    alu_v;
  logic                    alu_ill;

  assign in_ready  = rst_n & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == DONE);

  assign F        = f_q;
  assign zero     = zero_q;
  assign negative = neg_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;
  assign illegal  = ill_q;

  assign shamt   = B[SHAMT_WIDTH-1:0];
  assign add_ext = {1'b0, A} + {1'b0, B};
  assign sub_ext = {1'b0, A} - {1'b0, B};

  // Shifts run on a one-bit-extended copy of A so the last bit shifted out
  // lands in the extra bit; a zero amount leaves that bit 0.
  assign lsl_ext = {1'b0, A} << shamt;
  assign lsr_ext = {A, 1'b0} >> shamt;
  assign asr_ext = $unsigned($signed({A, 1'b0}) >>> shamt);

  assign mul_acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    alu_f   = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    case (select)
      OP_AND:   alu_f = A & B;
      OP_XOR:   alu_f = A ^ B;
      OP_OR:    alu_f = A | B;
      OP_PASSB: alu_f = B;
      OP_ADD: begin
        alu_f = add_ext[DATA_WIDTH-1:0];
        alu_c = add_ext[DATA_WIDTH];
        alu_v = (A[DATA_WIDTH-1] == B[DATA_WIDTH-1]) &
                (add_ext[DATA_WIDTH-1] != A[DATA_WIDTH-1]);
      end
      OP_SUB: begin
        alu_f = sub_ext[DATA_WIDTH-1:0];
        alu_c = ~sub_ext[DATA_WIDTH];
        alu_v = (A[DATA_WIDTH-1] != B[DATA_WIDTH-1]) &
                (sub_ext[DATA_WIDTH-1] != A[DATA_WIDTH-1]);
      end
      OP_LSL: begin
        alu_f = lsl_ext[DATA_WIDTH-1:0];
        alu_c = lsl_ext[DATA_WIDTH];
      end
      OP_LSR: begin
        alu_f = lsr_ext[DATA_WIDTH:1];
        alu_c = lsr_ext[0];
      end
      OP_ASR: begin
        alu_f = asr_ext[DATA_WIDTH:1];
        alu_c = asr_ext[0];
      end
      default:  alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    f_d      = f_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    ill_d    = ill_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;

    case (state_q)
      BUSY: begin
        acc_d    = mul_acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_WIDTH'(DATA_WIDTH - 1)) begin
          f_d     = mul_acc_next;
          zero_d  = (mul_acc_next == '0);
          neg_d   = mul_acc_next[DATA_WIDTH-1];
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          ill_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready && !in_valid) begin
          state_d = IDLE;
        end
      end
      default: ;
    endcase

    // IDLE and DONE share the accept path; in_ready already folds in
    // which of the two states may take a request this cycle.
    if (accept) begin
      if (select == OP_MUL) begin
        mcand_d  = A;
        mplier_d = B;
        acc_d    = '0;
        cnt_d    = '0;
        state_d  = BUSY;
      end else begin
        f_d     = alu_f;
        zero_d  = ~alu_ill & (alu_f == '0);
        neg_d   = ~alu_ill & alu_f[DATA_WIDTH-1];
        carry_d = alu_c;
        ovf_d   = alu_v;
        ill_d   = alu_ill;
        state_d = DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      f_q      <= '0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      f_q      <= f_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      ill_q    <= ill_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  localparam int unsigned W = 64;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    select;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  F;
  logic          zero;
  logic          negative;
  logic          carry;
  logic          overflow;
  logic          illegal;

  alu_seq #(
    .DATA_WIDTH (W),
    .SEL_WIDTH  (4),
    .SHAMT_WIDTH(6)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .select   (select),
    .A        (A),
    .B        (B),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .F        (F),
    .zero     (zero),
    .negative (negative),
    .carry    (carry),
    .overflow (overflow),
    .illegal  (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // flags packed as {zero, negative, carry, overflow}
  typedef struct {
    logic [3:0]   sel;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] f;
    logic [3:0]   fl;
    logic         ill;
    int           lat;
  } vec_t;

  // Reference model from the opcode rules, using plain wide arithmetic.
  task automatic model(input logic [3:0] sel, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] f, output logic [3:0] fl, output logic ill,
                       output int lat);
    logic z, n, c, v;
    logic [127:0] wide;
    logic signed [W:0] s;
    int amt;
    f = '0; z = 0; n = 0; c = 0; v = 0; ill = 0; lat = 1;
    amt = int'(b[5:0]);
    case (sel)
      4'd0: f = a & b;
      4'd1: f = a ^ b;
      4'd3: f = a | b;
      4'd9: f = b;
      4'd2: begin
        wide = {64'd0, a} + {64'd0, b};
        f = wide[W-1:0];
        c = wide[W];
        s = $signed({a[W-1], a}) + $signed({b[W-1], b});
        v = (s > 65'sh0_7FFF_FFFF_FFFF_FFFF) || (s < -65'sh0_8000_0000_0000_0000);
      end
      4'd6: begin
        f = a - b;
        c = (a >= b);
        s = $signed({a[W-1], a}) - $signed({b[W-1], b});
        v = (s > 65'sh0_7FFF_FFFF_FFFF_FFFF) || (s < -65'sh0_8000_0000_0000_0000);
      end
      4'd4: begin
        f = a << amt;
        c = (amt == 0) ? 1'b0 : a[W - amt];
      end
      4'd5: begin
        f = a >> amt;
        c = (amt == 0) ? 1'b0 : a[amt - 1];
      end
      4'd7: begin
        f = $signed(a) >>> amt;
        c = (amt == 0) ? 1'b0 : a[amt - 1];
      end
      4'd8: begin
        wide = {64'd0, a} * {64'd0, b};
        f = wide[W-1:0];
        lat = 65;
      end
      default: ill = 1;
    endcase
    if (!ill) begin
      z = (f == '0);
      n = f[W-1];
    end
    fl = {z, n, c, v};
  endtask

  // Issue one op with out_ready low after accept, hold the result `hold`
  // extra cycles, then sample and release it.
  task automatic run_op(input logic [3:0] sel, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold, output logic [W-1:0] f, output logic [3:0] fl,
                        output logic ill, output int lat);
    int guard;
    f = '0; fl = '0; ill = 0; lat = -1;
    @(negedge clk);
    select = sel; A = a; B = b; in_valid = 1; out_ready = 1;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready stayed 0, expected 1");
      in_valid = 0;
      return;
    end
    @(posedge clk);
    #1 in_valid = 0; out_ready = 0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 200);
    repeat (hold) @(negedge clk);
    f = F; fl = {zero, negative, carry, overflow}; ill = illegal;
    out_ready = 1;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    logic [W-1:0] f, ef;
    logic [3:0]   fl, efl;
    logic         il, eil;
    int           lat, elat;
    int           bad;

    rst_n = 0; in_valid = 0; out_ready = 0; select = '0; A = '0; B = '0;

    vecs.push_back('{4'd2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 4'b0101, 1'b0, 1});
    vecs.push_back('{4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'b1010, 1'b0, 1});
    vecs.push_back('{4'd6, 64'd5, 64'd5, 64'd0, 4'b1010, 1'b0, 1});
    vecs.push_back('{4'd6, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0100, 1'b0, 1});
    vecs.push_back('{4'd6, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011, 1'b0, 1});
    vecs.push_back('{4'd4, 64'h8000_0000_0000_0001, 64'd1, 64'd2, 4'b0010, 1'b0, 1});
    vecs.push_back('{4'd7, 64'h8000_0000_0000_0000, 64'h43, 64'hF000_0000_0000_0000, 4'b0100, 1'b0, 1});
    vecs.push_back('{4'd5, 64'hF8, 64'h104, 64'hF, 4'b0010, 1'b0, 1});
    vecs.push_back('{4'd5, 64'h1234, 64'h40, 64'h1234, 4'b0000, 1'b0, 1});
    vecs.push_back('{4'd5, 64'hC000_0000_0000_0000, 64'd63, 64'd1, 4'b0010, 1'b0, 1});
    vecs.push_back('{4'd0, 64'hFF00, 64'h0FF0, 64'h0F00, 4'b0000, 1'b0, 1});
    vecs.push_back('{4'd1, 64'hAAAA, 64'hAAAA, 64'd0, 4'b1000, 1'b0, 1});
    vecs.push_back('{4'd3, 64'h8000_0000_0000_0000, 64'd1, 64'h8000_0000_0000_0001, 4'b0100, 1'b0, 1});
    vecs.push_back('{4'd9, 64'h1234, 64'd0, 64'd0, 4'b1000, 1'b0, 1});
    vecs.push_back('{4'd15, 64'd5, 64'd7, 64'd0, 4'b0000, 1'b1, 1});
    vecs.push_back('{4'd10, 64'hFFFF, 64'hFFFF, 64'd0, 4'b0000, 1'b1, 1});
    vecs.push_back('{4'd8, 64'h1_0000_0001, 64'd3, 64'h3_0000_0003, 4'b0000, 1'b0, 65});
    vecs.push_back('{4'd8, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0000, 1'b0, 65});

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_F", F, 64'd0);
    chk("rst_flags", 64'({zero, negative, carry, overflow, illegal}), 64'd0);
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // directed vector table
    foreach (vecs[i]) begin
      run_op(vecs[i].sel, vecs[i].a, vecs[i].b, 0, f, fl, il, lat);
      chk($sformatf("vec%0d_F", i), f, vecs[i].f);
      chk($sformatf("vec%0d_flags", i), 64'(fl), 64'(vecs[i].fl));
      chk($sformatf("vec%0d_illegal", i), 64'(il), 64'(vecs[i].ill));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
    end

    // MUL: no accept while busy, result exactly 65 cycles after accept
    @(negedge clk);
    select = 4'd8; A = 64'h1_0000_0001; B = 64'd3; in_valid = 1; out_ready = 0;
    @(posedge clk);
    #1 select = 4'd2; A = 64'd1; B = 64'd1;
    bad = 0;
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      if (in_ready || out_valid) bad++;
    end
    chk("mul_busy_cycles", 64'(bad), 64'd0);
    @(negedge clk);
    chk("mul_out_valid_65", 64'(out_valid), 64'd1);
    chk("mul_F", F, 64'h3_0000_0003);
    in_valid = 0; out_ready = 1;
    @(posedge clk);
    #1;

    // backpressure: AND result held, queued XOR taken on release
    @(negedge clk);
    select = 4'd0; A = 64'hF0F0; B = 64'hFF00; in_valid = 1; out_ready = 0;
    @(posedge clk);
    #1 in_valid = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_out_valid", c), 64'(out_valid), 64'd1);
      chk($sformatf("stall%0d_F", c), F, 64'hF000);
      chk($sformatf("stall%0d_flags", c), 64'({zero, negative, carry, overflow}), 64'd0);
      chk($sformatf("stall%0d_in_ready", c), 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    select = 4'd1; A = 64'hFF; B = 64'h0F; in_valid = 1; out_ready = 1;
    #1 chk("queued_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 0; out_ready = 0;
    @(negedge clk);
    chk("xor_out_valid", 64'(out_valid), 64'd1);
    chk("xor_F", F, 64'hF0);
    out_ready = 1;
    @(posedge clk);
    #1;

    // async reset in the middle of a MUL
    run_op(4'd9, 64'd0, 64'hDEAD, 0, f, fl, il, lat);
    chk("pre_rst_F", f, 64'hDEAD);
    @(negedge clk);
    select = 4'd8; A = 64'd7; B = 64'd9; in_valid = 1; out_ready = 1;
    @(posedge clk);
    #1 in_valid = 0;
    repeat (20) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_F", F, 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1;
    #1 chk("arst_release_in_ready", 64'(in_ready), 64'd1);
    bad = 0;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    chk("arst_no_stale_result", 64'(bad), 64'd0);

    // randomized ops against the reference model
    for (int i = 0; i < 150; i++) begin
      logic [3:0]   rs;
      logic [W-1:0] ra, rb;
      rs = 4'($urandom_range(0, 15));
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      if ($urandom_range(0, 3) == 0) rb = W'($urandom_range(0, 3));
      model(rs, ra, rb, ef, efl, eil, elat);
      run_op(rs, ra, rb, $urandom_range(0, 2), f, fl, il, lat);
      chk($sformatf("rnd%0d_op%0d_F", i, rs), f, ef);
      chk($sformatf("rnd%0d_op%0d_flags", i, rs), 64'(fl), 64'(efl));
      chk($sformatf("rnd%0d_op%0d_illegal", i, rs), 64'(il), 64'(eil));
      chk($sformatf("rnd%0d_op%0d_latency", i, rs), 64'(lat), 64'(elat));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the datapath's combinational ALU: same operation encoding for AND/XOR/ADD/SUB, plus OR, shifts, pass-B and an iterative multiply.
- Adds NZCV flags and valid/ready handshakes on both sides.
- Sits between the register-file read stage and writeback.
- Result and flags are held in output registers until the consumer accepts them.

Parameters:
- DATA_WIDTH, 64, operand/result width; power of two, ≥8.
- SEL_WIDTH, 4, opcode width.
- SHAMT_WIDTH, log2(DATA_WIDTH), number of low B bits used as shift amount.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation request
- in_ready  output  1  block can accept a request this cycle
- select  input  SEL_WIDTH  opcode
- A  input  DATA_WIDTH  operand A
- B  input  DATA_WIDTH  operand B (low SHAMT_WIDTH bits are the shift amount)
- out_valid  output  1  F/flags valid
- out_ready  input  1  consumer accepts result
- F  output  DATA_WIDTH  result
- zero  output  1  Z flag
- negative  output  1  N flag
- carry  output  1  C flag
- overflow  output  1  V flag
- illegal  output  1  opcode was unassigned

Behaviour:
- Opcodes:
  - 0000 AND
  - 0001 XOR
  - 0010 ADD
  - 0011 OR
  - 0100 LSL
  - 0101 LSR
  - 0110 SUB (A-B)
  - 0111 ASR
  - 1000 MUL (low DATA_WIDTH bits of A*B, unsigned)
  - 1001 PASSB
  - Any other opcode: F=0, illegal=1, all four flags 0.
- Reset (async, rst_n=0): state=IDLE; F=0, zero=0, negative=0, carry=0, overflow=0, illegal=0, out_valid=0, in_ready=0 while rst_n low. Reset mid-MUL abandons the operation; no result is produced.
- Accept: request is taken on a rising edge with in_valid & in_ready. A, B and select are captured at that edge.
- in_ready = (state==IDLE) | (state==DONE & out_ready). This allows back-to-back operations at 1/cycle for single-cycle ops.
- States:
  - IDLE, on accept:
    - Non-MUL op: result registered at the same edge, go to DONE (latency 1 cycle, out_valid high the cycle after accept).
    - MUL: load multiplicand/multiplier/accumulator and count=0, go to BUSY.
  - BUSY: one shift-add step per cycle. After DATA_WIDTH steps, registers F/flags and goes to DONE. out_valid rises DATA_WIDTH+1 cycles after accept. in_ready=0 throughout. in_valid is ignored.
  - DONE:
    - out_valid=1; F, flags and illegal held stable until out_ready=1.
    - On out_ready & in_valid: accept the new op with the same transitions as IDLE.
    - On out_ready & !in_valid: go to IDLE, out_valid=0.
- Flags, computed on F:
  - zero = (F==0)
  - negative = F[DATA_WIDTH-1]
  - ADD: carry = carry-out of bit DATA_WIDTH-1; overflow = signed overflow.
  - SUB: carry = 1 when no borrow (A>=B unsigned); overflow = signed overflow of A-B.
  - LSL/LSR/ASR: carry = last bit shifted out; amount 0 gives F=A and carry=0. overflow=0.
  - AND/XOR/OR/PASSB/MUL: carry=0, overflow=0.
- Shifts: the amount is B[SHAMT_WIDTH-1:0] only; upper B bits are ignored. ASR replicates A[DATA_WIDTH-1].
- F and the flags never change while out_valid=1 and out_ready=0.

Test Plan:
- Reset, then ADD A=0x7FFF_FFFF_FFFF_FFFF, B=1 -> one cycle later out_valid=1, F=0x8000_0000_0000_0000, negative=1, overflow=1, carry=0, zero=0.
- SUB A=5, B=5 -> F=0, zero=1, carry=1. Then SUB A=3, B=5 -> F=0xFFFF_FFFF_FFFF_FFFE, carry=0, negative=1.
- MUL A=0x1_0000_0001, B=3 -> in_ready=0 for 64 cycles, out_valid exactly 65 cycles after accept, F=0x3_0000_0003. A new in_valid during BUSY is not accepted.
- Shifts:
  - LSL A=0x8000_0000_0000_0001, B=1 -> F=2, carry=1.
  - ASR A=0x8000_0000_0000_0000, B=0x43 -> amount 3, F=0xF000_0000_0000_0000, carry=0.
- Backpressure: hold out_ready=0 for 5 cycles after an AND result -> F/flags stable, in_ready=0. Then out_ready=1 with a queued XOR request -> XOR accepted on that edge and its result valid the next cycle. Opcode 1111 -> F=0, illegal=1.
- Async reset: assert rst_n=0 between clock edges at cycle 20 of a MUL -> out_valid=0 and F=0 immediately. After release the block is in IDLE with in_ready=1 and no stale result appears.
